// File: rtl/fma_pkg.sv
// Shared constants for the FMA back end: parameter defaults, RISC-V rounding modes,
// fflags bit positions and the rounding-decision helpers.
package fma_pkg;

  localparam int unsigned PARM_EXP_DEF  = 8;
  localparam int unsigned PARM_MANT_DEF = 23;
  localparam int unsigned PARM_BIAS_DEF = 127;

  // Width of the aligned-adder magnitude and the bit the leading one is normalized to.
  localparam int unsigned MANT_IN_W = 75;
  localparam int unsigned MANT_TOP  = MANT_IN_W - 1;

  typedef enum logic [2:0] {
    RmRne = 3'b000,
    RmRtz = 3'b001,
    RmRdn = 3'b010,
    RmRup = 3'b011,
    RmRmm = 3'b100
  } rm_e;

  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  // Reserved encodings round to nearest-even.
  function automatic rm_e decode_rm(input logic [2:0] rm);
    case (rm)
      3'b001:  return RmRtz;
      3'b010:  return RmRdn;
      3'b011:  return RmRup;
      3'b100:  return RmRmm;
      default: return RmRne;
    endcase
  endfunction

  // Whether the truncated magnitude must be incremented by one ulp.
  function automatic logic round_inc(input rm_e rm, input logic sign, input logic lsb,
                                     input logic guard, input logic sticky);
    case (rm)
      RmRne:   return guard & (sticky | lsb);
      RmRtz:   return 1'b0;
      RmRdn:   return (guard | sticky) & sign;
      RmRup:   return (guard | sticky) & ~sign;
      RmRmm:   return guard;
      default: return 1'b0;
    endcase
  endfunction

  // Overflow saturates to infinity only when the mode rounds away from zero for this sign.
  function automatic logic ovf_to_inf(input rm_e rm, input logic sign);
    case (rm)
      RmRne:   return 1'b1;
      RmRmm:   return 1'b1;
      RmRup:   return ~sign;
      RmRdn:   return sign;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lzc75.sv
// Leading-zero counter for the 75-bit aligned magnitude; count is 75 when the input is zero.
module lzc75 (
  input  logic [74:0] data,
  output logic [6:0]  count,
  output logic        all_zero
);

  // Scanning upward lets the most significant set bit win.
  always_comb begin
    count = 7'd75;
    for (int i = 0; i < 75; i++) begin
      if (data[i]) begin
        count = 7'(74 - i);
      end
    end
  end

  assign all_zero = ~|data;

endmodule

// File: rtl/normalize_round.sv
// Two-stage normalize/round/pack back end: S1 leading-zero shift, S2 round and exceptions.
// Define NORM_SUBNORM_EN to produce subnormal results instead of flushing tiny results to zero.
module normalize_round
  import fma_pkg::*;
#(
  parameter int unsigned PARM_EXP  = PARM_EXP_DEF,
  parameter int unsigned PARM_MANT = PARM_MANT_DEF,
  parameter int unsigned PARM_BIAS = PARM_BIAS_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [74:0]                   Mant_i,
  input  logic [PARM_EXP+1:0]           Exp_i,
  input  logic                          Sign_i,
  input  logic                          Sticky_i,
  input  logic [2:0]                    Rm_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [PARM_EXP+PARM_MANT:0]   Result_o,
  output logic [4:0]                    Fflags_o
);

  localparam int unsigned EW     = PARM_EXP + 4;
  localparam int unsigned RW     = PARM_EXP + PARM_MANT + 1;
  localparam int unsigned MW     = PARM_MANT + 1;
  localparam int unsigned GB     = MANT_TOP - MW;
  localparam int unsigned ExpMax = 2 * PARM_BIAS + 1;

  localparam logic signed [EW-1:0] ExpZero = '0;
  localparam logic signed [EW-1:0] ExpOne  = EW'(1);
  localparam logic signed [EW-1:0] ExpTop  = EW'(ExpMax);

  // ---------------------------------------------------------------- handshake
  logic s1_valid_q, s2_valid_q;
  logic s1_en, s2_en;

  assign s2_en   = ~s2_valid_q | ready_i;
  assign s1_en   = ~s1_valid_q | s2_en;
  assign ready_o = s1_en;
  assign valid_o = s2_valid_q;

  // ---------------------------------------------------------------- stage 1
  logic [6:0]             lz;
  logic                   lz_zero;
  logic signed [EW-1:0]   exp_ext;
  logic [74:0]            s1_mant_d;
  logic signed [EW-1:0]   s1_exp_d;

  lzc75 u_lzc (
    .data     (Mant_i),
    .count    (lz),
    .all_zero (lz_zero)
  );

  always_comb begin
    exp_ext   = {{2{Exp_i[PARM_EXP+1]}}, Exp_i};
    s1_mant_d = Mant_i << lz;
    s1_exp_d  = exp_ext + ExpOne - $signed(EW'(lz));
  end

  logic [74:0]          s1_mant_q;
  logic signed [EW-1:0] s1_exp_q;
  logic                 s1_sign_q;
  logic                 s1_sticky_q;
  logic                 s1_zero_q;
  rm_e                  s1_rm_q;

  // ---------------------------------------------------------------- stage 2
  logic [MW-1:0]        mant;
  logic                 guard;
  logic                 sticky;
  logic                 inc;
  logic [MW:0]          mant_r;
  logic                 carry;
  logic signed [EW-1:0] exp_r;
  logic                 tiny_in;
  logic [RW-1:0]        inf_val;
  logic [RW-1:0]        maxf_val;

  always_comb begin
    mant     = s1_mant_q[MANT_TOP -: MW];
    guard    = s1_mant_q[GB];
    sticky   = (|s1_mant_q[GB-1:0]) | s1_sticky_q;
    inc      = round_inc(s1_rm_q, s1_sign_q, mant[0], guard, sticky);
    mant_r   = {1'b0, mant} + (MW + 1)'(inc);
    carry    = mant_r[MW];
    exp_r    = s1_exp_q + $signed({{(EW - 1){1'b0}}, carry});
    // A zero magnitude carrying only sticky is below every normal, so route it as tiny.
    tiny_in  = (s1_exp_q <= ExpZero) | ~s1_mant_q[MANT_TOP];
    inf_val  = {s1_sign_q, {PARM_EXP{1'b1}}, {PARM_MANT{1'b0}}};
    maxf_val = {s1_sign_q, PARM_EXP'(ExpMax - 1), {PARM_MANT{1'b1}}};
  end

`ifdef NORM_SUBNORM_EN
  localparam int unsigned          ShCap  = PARM_MANT + 3;
  localparam logic [EW-1:0]        ShCapW = EW'(ShCap);

  logic [EW-1:0]     sh_full;
  logic [EW-1:0]     sh;
  logic [2*MW+1:0]   sub_ext;
  logic [MW-1:0]     sub_mant;
  logic              sub_guard;
  logic              sub_sticky;
  logic              sub_inc;
  logic [MW-1:0]     sub_r;
  logic              tiny_after;

  always_comb begin
    sh_full    = ExpOne - s1_exp_q;
    sh         = (sh_full > ShCapW) ? ShCapW : sh_full;
    sub_ext    = {mant, guard, {(MW + 1){1'b0}}} >> sh;
    sub_mant   = sub_ext[2*MW+1 -: MW];
    sub_guard  = sub_ext[MW];
    sub_sticky = (|sub_ext[MW-1:0]) | sticky;
    sub_inc    = round_inc(s1_rm_q, s1_sign_q, sub_mant[0], sub_guard, sub_sticky);
    sub_r      = sub_mant + MW'(sub_inc);
    // Tininess after rounding: only e==0 with a carry at full precision escapes.
    tiny_after = ~((s1_exp_q == ExpZero) & carry);
  end
`endif

  logic [RW-1:0] result_d;
  logic [4:0]    fflags_d;

  always_comb begin
    result_d = {s1_sign_q, exp_r[PARM_EXP-1:0], mant_r[PARM_MANT-1:0]};
    fflags_d = '0;
    if (s1_zero_q) begin
      result_d = {s1_sign_q, {(RW - 1){1'b0}}};
    end else if (tiny_in) begin
`ifdef NORM_SUBNORM_EN
      result_d          = {s1_sign_q, {(PARM_EXP - 1){1'b0}}, sub_r[MW-1],
                           sub_r[PARM_MANT-1:0]};
      fflags_d[FLAG_NX] = sub_guard | sub_sticky;
      fflags_d[FLAG_UF] = tiny_after & (sub_guard | sub_sticky);
`else
      result_d          = {s1_sign_q, {(RW - 1){1'b0}}};
      fflags_d[FLAG_NX] = 1'b1;
      fflags_d[FLAG_UF] = 1'b1;
`endif
    end else if (exp_r >= ExpTop) begin
      result_d          = ovf_to_inf(s1_rm_q, s1_sign_q) ? inf_val : maxf_val;
      fflags_d[FLAG_OF] = 1'b1;
      fflags_d[FLAG_NX] = 1'b1;
    end else begin
      fflags_d[FLAG_NX] = guard | sticky;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{mant_r[PARM_MANT], exp_r[EW-1:PARM_EXP]};

  // ---------------------------------------------------------------- registers
  logic [RW-1:0] s2_result_q;
  logic [4:0]    s2_fflags_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q  <= 1'b0;
      s1_mant_q   <= '0;
      s1_exp_q    <= '0;
      s1_sign_q   <= 1'b0;
      s1_sticky_q <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_rm_q     <= RmRne;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_fflags_q <= '0;
    end else begin
      if (s1_en) begin
        s1_valid_q <= valid_i;
        if (valid_i) begin
          s1_mant_q   <= s1_mant_d;
          s1_exp_q    <= s1_exp_d;
          s1_sign_q   <= Sign_i;
          s1_sticky_q <= Sticky_i;
          s1_zero_q   <= lz_zero & ~Sticky_i;
          s1_rm_q     <= decode_rm(Rm_i);
        end
      end
      if (s2_en) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_result_q <= result_d;
          s2_fflags_q <= fflags_d;
        end
      end
    end
  end

  assign Result_o = s2_result_q;
  assign Fflags_o = s2_fflags_q;

endmodule

// File: tb/tb_normalize_round.sv
// Scoreboard bench for normalize_round: directed vectors with hand-derived expectations,
// backpressure, latency and reset behaviour. Expectations follow NORM_SUBNORM_EN.
module tb_normalize_round;

  localparam logic [4:0] F_NX = 5'b00001;
  localparam logic [4:0] F_UF = 5'b00010;
  localparam logic [4:0] F_OF = 5'b00100;
  localparam logic [2:0] RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010, RUP = 3'b011, RMM = 3'b100;

`ifdef NORM_SUBNORM_EN
  localparam logic [31:0] R_G = 32'h00400000; localparam logic [4:0] F_G = 5'b0;
  localparam logic [31:0] R_R = 32'h80040000; localparam logic [4:0] F_R = 5'b0;
  localparam logic [31:0] R_S = 32'h00800000; localparam logic [4:0] F_S = F_UF | F_NX;
  localparam logic [31:0] R_T = 32'h00800000; localparam logic [4:0] F_T = F_NX;
`else
  localparam logic [31:0] R_G = 32'h00000000; localparam logic [4:0] F_G = F_UF | F_NX;
  localparam logic [31:0] R_R = 32'h80000000; localparam logic [4:0] F_R = F_UF | F_NX;
  localparam logic [31:0] R_S = 32'h00000000; localparam logic [4:0] F_S = F_UF | F_NX;
  localparam logic [31:0] R_T = 32'h00000000; localparam logic [4:0] F_T = F_UF | F_NX;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [74:0] Mant_i;
  logic [9:0]  Exp_i;
  logic        Sign_i;
  logic        Sticky_i;
  logic [2:0]  Rm_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] Result_o;
  logic [4:0]  Fflags_o;

  always #5 clk_i = ~clk_i;

  normalize_round dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .Mant_i   (Mant_i),
    .Exp_i    (Exp_i),
    .Sign_i   (Sign_i),
    .Sticky_i (Sticky_i),
    .Rm_i     (Rm_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .Result_o (Result_o),
    .Fflags_o (Fflags_o)
  );

  typedef struct {
    logic        sign;
    logic [74:0] mant;
    logic [9:0]  expo;
    logic        sticky;
    logic [2:0]  rm;
    logic [31:0] res;
    logic [4:0]  flg;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          n_out  = 0;
  logic [36:0] exp_q[$];
  logic [36:0] want;
  logic [74:0] one = 75'd1;

  function automatic vec_t mk(input logic s, input logic [74:0] m, input logic [9:0] e,
                              input logic st, input logic [2:0] rm, input logic [31:0] r,
                              input logic [4:0] f);
    vec_t v;
    v.sign = s; v.mant = m; v.expo = e; v.sticky = st; v.rm = rm; v.res = r; v.flg = f;
    return v;
  endfunction

  // Drives one cycle of stimulus; outputs are stable for sampling when it returns.
  task automatic drive(input logic v, input vec_t t, input logic rdy, output logic acc);
    @(negedge clk_i);
    valid_i  = v;
    Mant_i   = t.mant;
    Exp_i    = t.expo;
    Sign_i   = t.sign;
    Sticky_i = t.sticky;
    Rm_i     = t.rm;
    ready_i  = rdy;
    #1;
    acc = v && ready_o;
    if (acc) exp_q.push_back({t.res, t.flg});
  endtask

  task automatic test_reset;
    rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    Mant_i = '0; Exp_i = '0; Sign_i = 1'b0; Sticky_i = 1'b0; Rm_i = RNE;
    repeat (3) @(negedge clk_i);
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", valid_o); end
    checks++; if (Result_o !== 32'h0) begin errors++; $display("FAIL rst_result: got %h required 0", Result_o); end
    checks++; if (Fflags_o !== 5'h0) begin errors++; $display("FAIL rst_flags: got %b required 0", Fflags_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b required 1", ready_o); end
  endtask

  // First operand right after reset release, checking two-cycle latency.
  task automatic test_latency;
    vec_t v = mk(0, one << 73, 10'd127, 0, RNE, 32'h3F800000, 5'b0);
    logic acc;
    @(negedge clk_i);
    rst_ni = 1'b1; valid_i = 1'b1; Mant_i = v.mant; Exp_i = v.expo; Sign_i = v.sign;
    Sticky_i = v.sticky; Rm_i = v.rm; ready_i = 1'b1;
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL first_accept: ready_o %b required 1", ready_o); end
    drive(0, v, 1, acc);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL latency_1: valid_o %b required 0", valid_o); end
    drive(0, v, 1, acc);
    checks++;
    if (valid_o !== 1'b1) begin
      errors++; $display("FAIL latency_2: valid_o %b required 1", valid_o);
    end else if ({Result_o, Fflags_o} !== {v.res, v.flg}) begin
      errors++; $display("FAIL one_rne: got %h/%b required %h/%b", Result_o, Fflags_o, v.res, v.flg);
    end
    drive(0, v, 1, acc);
  endtask

  task automatic test_vectors;
    vec_t vs[$];
    vec_t idle;
    logic acc;
    int   guard_cnt;
    vs.push_back(mk(0, one << 73, 10'd127, 0, RNE, 32'h3F800000, 5'b0));
    vs.push_back(mk(0, (one << 73) | (one << 49), 10'd127, 0, RNE, 32'h3F800000, F_NX));
    vs.push_back(mk(0, (one << 73) | (one << 49), 10'd127, 0, RUP, 32'h3F800001, F_NX));
    vs.push_back(mk(0, one << 74, 10'd254, 0, RNE, 32'h7F800000, F_OF | F_NX));
    vs.push_back(mk(0, one << 74, 10'd254, 0, RTZ, 32'h7F7FFFFF, F_OF | F_NX));
    vs.push_back(mk(1, '0, 10'd127, 0, RNE, 32'h80000000, 5'b0));
    vs.push_back(mk(0, one << 73, 10'd0, 0, RNE, R_G, F_G));
    vs.push_back(mk(0, (one << 73) | (one << 50) | (one << 49), 10'd127, 0, RNE, 32'h3F800002, F_NX));
    vs.push_back(mk(0, ((one << 25) - one) << 49, 10'd127, 0, RNE, 32'h40000000, F_NX));
    vs.push_back(mk(0, ((one << 25) - one) << 49, 10'd127, 0, RTZ, 32'h3FFFFFFF, F_NX));
    vs.push_back(mk(1, one << 73, 10'd127, 1, RDN, 32'hBF800001, F_NX));
    vs.push_back(mk(0, one << 73, 10'd127, 1, RDN, 32'h3F800000, F_NX));
    vs.push_back(mk(0, (one << 73) | (one << 49), 10'd127, 0, RMM, 32'h3F800001, F_NX));
    vs.push_back(mk(0, (one << 73) | (one << 50) | (one << 49), 10'd127, 0, 3'b110, 32'h3F800002, F_NX));
    vs.push_back(mk(1, one << 74, 10'd254, 0, RUP, 32'hFF7FFFFF, F_OF | F_NX));
    vs.push_back(mk(1, one << 74, 10'd254, 0, RDN, 32'hFF800000, F_OF | F_NX));
    vs.push_back(mk(0, one, 10'd200, 0, RNE, 32'h3F800000, 5'b0));
    vs.push_back(mk(0, one << 10, 10'd150, 0, RNE, 32'h2B800000, 5'b0));
    vs.push_back(mk(1, one << 74, 10'h3FB, 0, RNE, R_R, F_R));
    vs.push_back(mk(0, ((one << 24) - one) << 50, 10'd0, 0, RNE, R_S, F_S));
    vs.push_back(mk(0, ((one << 25) - one) << 49, 10'd0, 0, RNE, R_T, F_T));
    idle = vs[0];
    for (int k = 0; k < vs.size() + 12; k++) begin
      if (k < vs.size()) drive(1, vs[k], 1, acc);
      else drive(0, idle, 1, acc);
      if (k < vs.size() && !acc) begin
        errors++; $display("FAIL vec_accept_%0d: ready_o %b required 1", k, ready_o);
      end
      if (valid_o && ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL vec_extra: got %h/%b required none", Result_o, Fflags_o);
        end else begin
          want = exp_q.pop_front();
          if ({Result_o, Fflags_o} !== want) begin
            errors++;
            $display("FAIL vec_%0d: got %h/%b required %h/%b", n_out, Result_o, Fflags_o,
                     want[36:5], want[4:0]);
          end
        end
        n_out++;
      end
    end
    guard_cnt = exp_q.size();
    checks++;
    if (guard_cnt != 0) begin
      errors++; $display("FAIL vec_drain: %0d results outstanding, required 0", guard_cnt);
      exp_q.delete();
    end
  endtask

  task automatic test_backpressure;
    vec_t ops[3];
    logic acc;
    int   idx = 0;
    ops[0] = mk(0, (one << 73) | (one << 49), 10'd127, 0, RUP, 32'h3F800001, F_NX);
    ops[1] = mk(0, one << 10, 10'd150, 0, RNE, 32'h2B800000, 5'b0);
    ops[2] = mk(0, (one << 73) | (one << 50) | (one << 49), 10'd127, 0, RNE, 32'h3F800002, F_NX);
    for (int i = 0; i < 16; i++) begin
      drive(idx < 3, ops[idx < 3 ? idx : 2], i >= 4, acc);
      if (i == 2) begin
        checks++;
        if (ready_o !== 1'b0 || idx != 2) begin
          errors++; $display("FAIL bp_stall: ready_o %b accepted %0d, required 0 and 2", ready_o, idx);
        end
      end
      if (valid_o && !ready_i && exp_q.size() > 0) begin
        checks++;
        if ({Result_o, Fflags_o} !== exp_q[0]) begin
          errors++; $display("FAIL bp_hold: got %h/%b required %h/%b", Result_o, Fflags_o,
                             exp_q[0][36:5], exp_q[0][4:0]);
        end
      end
      if (valid_o && ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra: got %h/%b required none", Result_o, Fflags_o);
        end else begin
          want = exp_q.pop_front();
          if ({Result_o, Fflags_o} !== want) begin
            errors++; $display("FAIL bp_order: got %h/%b required %h/%b", Result_o, Fflags_o,
                               want[36:5], want[4:0]);
          end
        end
      end
      if (acc) idx++;
    end
    checks++;
    if (idx != 3 || exp_q.size() != 0) begin
      errors++; $display("FAIL bp_drain: accepted %0d outstanding %0d, required 3 and 0", idx, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid;
    vec_t a = mk(0, one << 73, 10'd127, 0, RNE, 32'h3F800000, 5'b0);
    vec_t d = mk(0, one << 74, 10'd254, 0, RNE, 32'h7F800000, F_OF | F_NX);
    logic acc;
    drive(1, a, 0, acc);
    drive(1, d, 0, acc);
    drive(0, a, 0, acc);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL mid_full: valid_o %b required 1", valid_o); end
    rst_ni = 1'b0;
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b required 0", valid_o); end
    checks++; if (Result_o !== 32'h0) begin errors++; $display("FAIL mid_result: got %h required 0", Result_o); end
    checks++; if (Fflags_o !== 5'h0) begin errors++; $display("FAIL mid_flags: got %b required 0", Fflags_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b required 1", ready_o); end
    exp_q.delete();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(0, a, 1, acc);
      checks++;
      if (valid_o !== 1'b0) begin
        errors++; $display("FAIL mid_stale_%0d: valid_o %b result %h required 0", i, valid_o, Result_o);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation bound reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
